jtpang_sdram_arb: RTL and testbench

Arbiter and sequencer sharing one single-access SDRAM command core among the four ROM bank requesters (main/PCM/char/obj) and the download programming port. It grants one requester at a time, round-robin across banks, gives the download port priority while `downloading`, and schedules auto-refresh: forced when overdue, opportunistic during vertical blank. It sits between the bank ROM slots and the SDRAM core, routing the core's data handshakes back to the granted requester only.

---
 rtl/jtpang_sdram_arb_if.sv | 54 +++++
 rtl/jtpang_sdram_arb.sv | 178 +++++++++++++++++
 tb/tb_jtpang_sdram_arb.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtpang_sdram_arb_if.sv
// Bank/programming requesters and SDRAM core handshake bundle
// seen by the jtpang SDRAM arbiter.
interface jtpang_sdram_arb_if;
  logic [21:0] ba0_addr;
  logic [21:0] ba1_addr;
  logic [21:0] ba2_addr;
  logic [21:0] ba3_addr;
  logic [3:0]  ba_rd;
  logic [3:0]  ba_ack;
  logic [3:0]  ba_dst;
  logic [3:0]  ba_dok;
  logic [3:0]  ba_rdy;
  logic [21:0] prog_addr;
  logic [1:0]  prog_ba;
  logic [15:0] prog_data;
  logic [1:0]  prog_mask;
  logic        prog_we;
  logic        prog_rd;
  logic        prog_ack;
  logic        prog_rdy;
  logic        core_req;
  logic        core_rfsh;
  logic        core_wr;
  logic [1:0]  core_ba;
  logic [21:0] core_addr;
  logic [15:0] core_din;
  logic [1:0]  core_mask;
  logic        core_ack;
  logic        core_dst;
  logic        core_dok;
  logic        core_rdy;

  modport slave (
    input  ba0_addr, ba1_addr, ba2_addr, ba3_addr, ba_rd,
    input  prog_addr, prog_ba, prog_data, prog_mask,
    input  prog_we, prog_rd,
    input  core_ack, core_dst, core_dok, core_rdy,
    output ba_ack, ba_dst, ba_dok, ba_rdy,
    output prog_ack, prog_rdy,
    output core_req, core_rfsh, core_wr, core_ba,
    output core_addr, core_din, core_mask
  );

  modport master (
    output ba0_addr, ba1_addr, ba2_addr, ba3_addr, ba_rd,
    output prog_addr, prog_ba, prog_data, prog_mask,
    output prog_we, prog_rd,
    output core_ack, core_dst, core_dok, core_rdy,
    input  ba_ack, ba_dst, ba_dok, ba_rdy,
    input  prog_ack, prog_rdy,
    input  core_req, core_rfsh, core_wr, core_ba,
    input  core_addr, core_din, core_mask
  );
endinterface

// File: rtl/jtpang_sdram_arb.sv
// Round-robin ROM bank arbiter with download priority and
// refresh scheduling in front of a single-access SDRAM core.
module jtpang_sdram_arb #(
  parameter int RFSH_MAX = 64,
  parameter int RFSH_OPP = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic LVBL,
  input  logic downloading,
  jtpang_sdram_arb_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    BUSY
  } state_t;

  typedef enum logic [2:0] {
    G_B0,
    G_B1,
    G_B2,
    G_B3,
    G_PROG,
    G_RFSH
  } own_t;

  localparam logic [7:0] MAX8 = 8'(RFSH_MAX);
  localparam logic [7:0] OPP8 = 8'(RFSH_OPP);

  state_t      st;
  own_t        own;
  logic [1:0]  last;
  logic [7:0]  rfsh_cnt;

  logic [3:0]  rd_m;
  logic [1:0]  bank_sel;
  logic [21:0] bank_addr;
  logic        bank_req;
  logic        prog_req;
  logic        rfsh_urg;
  logic        rfsh_opp;
  logic        go_urg;
  logic        go_prog;
  logic        go_bank;
  logic        go_opp;
  logic        ack_ev;
  logic        rdy_ev;
  logic        in_busy;
  logic        own_bank;
  logic        rfsh_clr;
  logic [3:0]  bank_oh;

  assign rd_m     = downloading ? 4'd0 : bus.ba_rd;
  assign bank_req = |rd_m;
  assign prog_req = downloading & (bus.prog_we | bus.prog_rd);
  assign rfsh_urg = rfsh_cnt >= MAX8;
  assign rfsh_opp = rfsh_cnt >= OPP8;

  // one-hot selection so the IDLE decoder needs no priority
  assign go_urg  = rfsh_urg;
  assign go_prog = !rfsh_urg && prog_req;
  assign go_bank = !rfsh_urg && !prog_req && bank_req;
  assign go_opp  = !rfsh_urg && !prog_req && !bank_req
                   && !LVBL && rfsh_opp;

  // scan last+1 .. last+4; the nearest requester wins
  always_comb begin
    bank_sel = last + 2'd1;
    for (int k = 4; k >= 1; k--) begin
      if (rd_m[last + 2'(k)]) bank_sel = last + 2'(k);
    end
  end

  always_comb begin
    bank_addr = bus.ba0_addr;
    unique case (bank_sel)
      2'd0: bank_addr = bus.ba0_addr;
      2'd1: bank_addr = bus.ba1_addr;
      2'd2: bank_addr = bus.ba2_addr;
      2'd3: bank_addr = bus.ba3_addr;
    endcase
  end

  assign in_busy  = st == BUSY;
  assign ack_ev   = st == GRANT && bus.core_ack;
  assign rdy_ev   = bus.core_rdy && (in_busy || ack_ev);
  assign own_bank = !own[2];
  assign bank_oh  = own_bank ? 4'b0001 << own[1:0] : 4'd0;
  assign rfsh_clr = ack_ev && own == G_RFSH;

  assign bus.ba_ack   = ack_ev ? bank_oh : 4'd0;
  assign bus.ba_dst   = in_busy && bus.core_dst ? bank_oh : 4'd0;
  assign bus.ba_dok   = in_busy && bus.core_dok ? bank_oh : 4'd0;
  assign bus.ba_rdy   = rdy_ev ? bank_oh : 4'd0;
  assign bus.prog_ack = ack_ev && own == G_PROG;
  assign bus.prog_rdy = rdy_ev && own == G_PROG;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st             <= IDLE;
      own            <= G_B0;
      last           <= 2'd3;
      rfsh_cnt       <= 8'd0;
      bus.core_req   <= 1'b0;
      bus.core_rfsh  <= 1'b0;
      bus.core_wr    <= 1'b0;
      bus.core_ba    <= 2'd0;
      bus.core_addr  <= 22'd0;
      bus.core_din   <= 16'd0;
      bus.core_mask  <= 2'd0;
    end else begin
      if (rfsh_clr) rfsh_cnt <= 8'd0;
      else if (rfsh_cnt != 8'hff) rfsh_cnt <= rfsh_cnt + 8'd1;
      unique case (st)
        IDLE: begin
          unique case (1'b1)
            go_urg, go_opp: begin
              own           <= G_RFSH;
              st            <= GRANT;
              bus.core_req  <= 1'b1;
              bus.core_rfsh <= 1'b1;
              bus.core_wr   <= 1'b0;
              bus.core_ba   <= 2'd0;
              bus.core_addr <= 22'd0;
              bus.core_din  <= 16'd0;
              bus.core_mask <= 2'd0;
            end
            go_prog: begin
              own           <= G_PROG;
              st            <= GRANT;
              bus.core_req  <= 1'b1;
              bus.core_rfsh <= 1'b0;
              bus.core_wr   <= bus.prog_we;
              bus.core_ba   <= bus.prog_ba;
              bus.core_addr <= bus.prog_addr;
              bus.core_din  <= bus.prog_data;
              bus.core_mask <= bus.prog_mask;
            end
            go_bank: begin
              own           <= own_t'({1'b0, bank_sel});
              st            <= GRANT;
              bus.core_req  <= 1'b1;
              bus.core_rfsh <= 1'b0;
              bus.core_wr   <= 1'b0;
              bus.core_ba   <= bank_sel;
              bus.core_addr <= bank_addr;
              bus.core_din  <= 16'd0;
              bus.core_mask <= 2'd0;
            end
            default: ;
          endcase
        end
        GRANT: begin
          if (bus.core_ack) begin
            bus.core_req  <= 1'b0;
            bus.core_rfsh <= 1'b0;
            if (bus.core_rdy) begin
              st <= IDLE;
              if (own_bank) last <= own[1:0];
            end else begin
              st <= BUSY;
            end
          end
        end
        BUSY: begin
          if (bus.core_rdy) begin
            st <= IDLE;
            if (own_bank) last <= own[1:0];
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtpang_sdram_arb.sv
// Randomised scoreboard bench for jtpang_sdram_arb with a
// reference arbiter model and a simple SDRAM core model.
module tb_jtpang_sdram_arb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic LVBL = 1'b1;
  logic downloading = 1'b0;

  jtpang_sdram_arb_if bus();

  jtpang_sdram_arb #(.RFSH_MAX(64), .RFSH_OPP(32)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .LVBL(LVBL),
    .downloading(downloading),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          own;
    logic [21:0] addr;
    logic [1:0]  ba;
    logic        wr;
    logic [15:0] din;
    logic [1:0]  mask;
    int          cyc;
  } cmd_t;

  cmd_t exp_q[$];
  logic [2:0] scr[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // reference model: owners 0..3 banks, 4 prog, 5 refresh
  bit m_idle = 1;
  int m_last = 3;
  int m_age = 0;
  int m_own = 0;
  int n_grant[6];

  // core model
  int c_st = 0;
  int c_dly = 0;
  logic c_ack, c_dst, c_dok, c_rdy;

  // stimulus knobs
  int p_bank = 0;
  int p_drop = 0;
  int p_prog = 0;
  bit k_lvbl = 1;
  bit k_dl = 0;
  logic [3:0] inj = 4'd0;
  logic [21:0] inj_addr[4];
  logic [21:0] baddr[4];
  logic [3:0] saw_ack = 4'd0;
  logic saw_pack = 1'b0;
  logic prev_req = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h cyc=%0d",
               nm, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] outs();
    return {1'b0, bus.ba_ack, bus.ba_dst, bus.ba_dok, bus.ba_rdy,
            bus.prog_ack, bus.prog_rdy, bus.core_req, bus.core_rfsh,
            bus.core_wr, bus.core_ba, bus.core_addr, bus.core_din,
            bus.core_mask};
  endfunction

  task automatic drive_core();
    bus.core_ack = c_ack;
    bus.core_dst = c_dst;
    bus.core_dok = c_dok;
    bus.core_rdy = c_rdy;
  endtask

  task automatic build_script(input bit is_read);
    int gap;
    int words;
    gap = $urandom_range(2);
    repeat (gap) scr.push_back(3'b000);
    if (is_read) begin
      words = $urandom_range(1, 4);
      scr.push_back(3'b110);
      for (int w = 1; w < words; w++) begin
        if ($urandom_range(3) == 0) scr.push_back(3'b000);
        scr.push_back(3'b010);
      end
    end
    scr.push_back(3'b001);
  endtask

  // one clock of stimulus, core response, checks and model update
  task automatic step();
    logic [3:0] e_oh;
    logic [2:0] e;
    int sel;
    int nxt_age;
    bit nxt_idle;
    cmd_t c;
    cyc++;
    LVBL = k_lvbl;
    downloading = k_dl;
    for (int i = 0; i < 4; i++) begin
      if (bus.ba_rd[i] && saw_ack[i]) begin
        bus.ba_rd[i] = 1'b0;
      end else if (bus.ba_rd[i] && !(!m_idle && m_own == i)
                   && $urandom_range(99) < p_drop) begin
        bus.ba_rd[i] = 1'b0;
      end else if (!bus.ba_rd[i] && $urandom_range(99) < p_bank) begin
        bus.ba_rd[i] = 1'b1;
        baddr[i] = 22'($urandom);
      end
      if (inj[i]) begin
        bus.ba_rd[i] = 1'b1;
        baddr[i] = inj_addr[i];
      end
    end
    inj = 4'd0;
    bus.ba0_addr = baddr[0];
    bus.ba1_addr = baddr[1];
    bus.ba2_addr = baddr[2];
    bus.ba3_addr = baddr[3];
    if ((bus.prog_we || bus.prog_rd) && saw_pack) begin
      bus.prog_we = 1'b0;
      bus.prog_rd = 1'b0;
    end else if (!(bus.prog_we || bus.prog_rd)
                 && $urandom_range(99) < p_prog) begin
      bus.prog_we = $urandom_range(1) == 1;
      bus.prog_rd = !bus.prog_we;
      bus.prog_addr = 22'($urandom);
      bus.prog_ba = 2'($urandom);
      bus.prog_data = 16'($urandom);
      bus.prog_mask = 2'($urandom);
    end
    c_ack = 0; c_dst = 0; c_dok = 0; c_rdy = 0;
    if (c_st == 0 && bus.core_req) begin
      c_st = 1;
      c_dly = $urandom_range(3);
    end
    if (c_st == 1) begin
      chk("req_hold", bus.core_req, 1);
      if (c_dly == 0) begin
        c_ack = 1;
        if ((bus.core_wr || bus.core_rfsh) && $urandom_range(1) == 1) begin
          c_rdy = 1;
          c_st = 0;
        end else begin
          build_script(!(bus.core_wr || bus.core_rfsh));
          c_st = 2;
        end
      end else begin
        c_dly--;
      end
    end else if (c_st == 2) begin
      e = scr.pop_front();
      {c_dst, c_dok, c_rdy} = e;
      if (c_rdy) c_st = 0;
    end
    drive_core();
    #1;
    e_oh = (m_own < 4) ? 4'b0001 << m_own : 4'd0;
    chk("ack", {bus.ba_ack, bus.prog_ack},
        {c_ack ? e_oh : 4'd0, c_ack && m_own == 4});
    chk("route", {bus.ba_dst, bus.ba_dok, bus.ba_rdy, bus.prog_rdy},
        {c_dst ? e_oh : 4'd0, c_dok ? e_oh : 4'd0,
         c_rdy ? e_oh : 4'd0, c_rdy && m_own == 4});
    saw_ack = bus.ba_ack;
    saw_pack = bus.prog_ack;
    nxt_idle = m_idle;
    nxt_age = m_age < 255 ? m_age + 1 : 255;
    if (!m_idle) begin
      if (c_ack && m_own == 5) nxt_age = 0;
      if (c_rdy) begin
        nxt_idle = 1;
        if (m_own < 4) m_last = m_own;
      end
    end else begin
      sel = -1;
      if (m_age >= 64) sel = 5;
      else if (downloading && (bus.prog_we || bus.prog_rd)) sel = 4;
      else if (!downloading && bus.ba_rd != 4'd0) begin
        for (int k = 1; k <= 4 && sel < 0; k++)
          if (bus.ba_rd[(m_last + k) % 4]) sel = (m_last + k) % 4;
      end else if (!LVBL && m_age >= 32) sel = 5;
      if (sel >= 0) begin
        c.own = sel;
        c.cyc = cyc;
        c.ba = (sel < 4) ? 2'(sel) : bus.prog_ba;
        c.addr = (sel < 4) ? baddr[sel] : bus.prog_addr;
        c.wr = (sel == 4) ? bus.prog_we : 1'b0;
        c.din = bus.prog_data;
        c.mask = bus.prog_mask;
        exp_q.push_back(c);
        m_own = sel;
        nxt_idle = 0;
        n_grant[sel]++;
      end
    end
    m_idle = nxt_idle;
    m_age = nxt_age;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      step();
    end
  endtask

  task automatic clear_model();
    m_idle = 1; m_last = 3; m_age = 0; m_own = 0;
    c_st = 0; c_ack = 0; c_dst = 0; c_dok = 0; c_rdy = 0;
    scr.delete();
    exp_q.delete();
    bus.ba_rd = 4'd0;
    bus.prog_we = 1'b0;
    bus.prog_rd = 1'b0;
    saw_ack = 4'd0;
    saw_pack = 1'b0;
    drive_core();
  endtask

  // monitor: every new core command pops one expected entry
  initial begin
    cmd_t c;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        prev_req = 1'b0;
      end else begin
        if (bus.core_req && !prev_req) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_req actual=1 expected=0 cyc=%0d", cyc);
          end else begin
            c = exp_q.pop_front();
            chk("req_latency", 64'(cyc), 64'(c.cyc + 1));
            chk("rfsh", bus.core_rfsh, c.own == 5);
            chk("wr", bus.core_wr, c.wr);
            if (c.own != 5)
              chk("ba_addr", {bus.core_ba, bus.core_addr}, {c.ba, c.addr});
            if (c.own == 4)
              chk("din_mask", {bus.core_din, bus.core_mask},
                  {c.din, c.mask});
          end
        end
        prev_req = bus.core_req;
      end
    end
  end

  initial begin
    int stale;
    int guard;
    for (int i = 0; i < 4; i++) begin
      baddr[i] = 22'd0;
      inj_addr[i] = 22'd0;
    end
    for (int i = 0; i < 6; i++) n_grant[i] = 0;
    bus.ba0_addr = 22'd0; bus.ba1_addr = 22'd0;
    bus.ba2_addr = 22'd0; bus.ba3_addr = 22'd0;
    bus.prog_addr = 22'd0; bus.prog_ba = 2'd0;
    bus.prog_data = 16'd0; bus.prog_mask = 2'd0;
    clear_model();
    repeat (3) @(negedge clk);
    #1 chk("reset_outputs", outs(), 64'd0);

    @(negedge clk);
    rst_n = 1'b1;
    inj = 4'b0100;
    inj_addr[2] = 22'h12345;
    step();
    run(20);

    p_bank = 40; p_drop = 2; k_lvbl = 1;
    run(800);
    k_dl = 1; p_prog = 50;
    run(400);
    k_dl = 0; p_prog = 0; k_lvbl = 0; p_bank = 3;
    run(400);
    p_bank = 0; p_drop = 0; k_lvbl = 1;
    run(200);

    guard = 0;
    while (!(m_idle && c_st == 0 && bus.ba_rd == 4'd0) && guard < 200) begin
      run(1);
      guard++;
    end
    chk("drain_timeout", 64'(guard < 200), 64'd1);
    inj = 4'b1000;
    inj_addr[3] = 22'h2abcde;
    guard = 0;
    do begin
      run(1);
      guard++;
    end while (!(!m_idle && m_own == 3 && c_st == 2) && guard < 100);
    chk("bank3_busy_timeout", 64'(guard < 100), 64'd1);
    #2 rst_n = 1'b0;
    #1 chk("reset_mid_busy", outs(), 64'd0);
    clear_model();
    repeat (2) @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    inj = 4'b1001;
    inj_addr[0] = 22'h0f0f0;
    inj_addr[3] = 22'h30303;
    step();
    run(60);

    stale = 0;
    foreach (exp_q[i]) if (exp_q[i].cyc < cyc) stale++;
    chk("queue_drained", 64'(stale), 64'd0);
    for (int i = 0; i < 6; i++)
      chk($sformatf("grant_seen_%0d", i), 64'(n_grant[i] > 0), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
